// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One combinational evaluation of the subtractive GCD recurrence.
// Terminates when the operands match or either is zero; otherwise the
// smaller operand is subtracted from the larger, so no underflow occurs.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic [WIDTH-1:0] ra_next,
  output logic [WIDTH-1:0] rb_next,
  output logic             term,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             step
);

  // Priority: terminate, then reduce ra, then reduce rb.
  always_comb begin
    ra_next = ra;
    rb_next = rb;
    term    = 1'b0;
    step    = 1'b0;
    result  = (ra == '0) ? rb : ra;
    zero    = (ra == '0) && (rb == '0);
    if ((ra == rb) || (ra == '0) || (rb == '0)) begin
      term = 1'b1;
    end else if (ra > rb) begin
      ra_next = ra - rb;
      step    = 1'b1;
    end else begin
      rb_next = rb - ra;
      step    = 1'b1;
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Iterative subtractive GCD with valid/ready handshakes on both sides.
// Optional feature macro: GCD_STEPS_EN adds the out_steps port and a
// subtraction-step counter.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero
`ifdef GCD_STEPS_EN
  ,
  output logic [WIDTH-1:0] out_steps
`endif
);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] ra_q, rb_q;
  logic [WIDTH-1:0] gcd_q;
  logic             zero_q;

  logic [WIDTH-1:0] ra_next, rb_next, step_result;
  logic             step_term, step_zero, step_inc;

`ifdef GCD_STEPS_EN
  logic [WIDTH-1:0] steps_q;
  logic [WIDTH-1:0] steps_out_q;
`endif

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .ra      (ra_q),
    .rb      (rb_q),
    .ra_next (ra_next),
    .rb_next (rb_next),
    .term    (step_term),
    .result  (step_result),
    .zero    (step_zero),
    .step    (step_inc)
  );

  // Next-state logic; acceptance only from IDLE, no DONE->accept bypass.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (step_term) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand, result and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      gcd_q   <= '0;
      zero_q  <= 1'b0;
`ifdef GCD_STEPS_EN
      steps_q     <= '0;
      steps_out_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ra_q <= in_a;
            rb_q <= in_b;
`ifdef GCD_STEPS_EN
            steps_q <= '0;
`endif
          end
        end
        StRun: begin
          if (step_inc) begin
            ra_q <= ra_next;
            rb_q <= rb_next;
`ifdef GCD_STEPS_EN
            steps_q <= steps_q + WIDTH'(1);
`endif
          end
          if (step_term) begin
            gcd_q  <= step_result;
            zero_q <= step_zero;
`ifdef GCD_STEPS_EN
            steps_out_q <= steps_q;
`endif
          end
        end
        StDone: begin
`ifdef GCD_STEPS_EN
          // Step count reads zero again once back in IDLE.
          if (out_ready) steps_out_q <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Reset overrides in_ready so it is low during the reset cycle.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    out_gcd   = gcd_q;
    out_zero  = zero_q;
`ifdef GCD_STEPS_EN
    out_steps = steps_out_q;
`endif
  end

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit (WIDTH=8): directed cases, reset abort,
// back-to-back pairs and random pairs against a Euclid-based reference.
module tb_gcd_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_zero;
`ifdef GCD_STEPS_EN
  logic [W-1:0] out_steps;
`endif

  int checks   = 0;
  int failures = 0;

  gcd_unit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_zero  (out_zero)
`ifdef GCD_STEPS_EN
    ,
    .out_steps (out_steps)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: gcd via Euclid's remainders; subtraction steps are the sum of
  // the quotients minus one (the final equal pair terminates instead).
  function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                  output int unsigned g, output bit z,
                                  output int unsigned s);
    int unsigned x, y, t;
    z = (a == 0) && (b == 0);
    s = 0;
    if (a == 0 || b == 0) begin
      g = a + b;
      return;
    end
    x = a;
    y = b;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    s -= 1;
  endfunction

  // Offer one pair at a negedge in IDLE, then check latency, result and hold.
  task automatic run_pair(input int unsigned a, input int unsigned b, input int hold);
    int unsigned g, s;
    bit          z;
    int          k;
    ref_gcd(a, b, g, z, s);
    out_ready = 1'b0;
    in_a      = W'(a);
    in_b      = W'(b);
    in_valid  = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_run", in_ready, 0);
    k = 1;
    while (!out_valid && k < 600) begin
      // Operand and in_valid noise while busy must not disturb the result.
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check("latency", k, s + 2);
    check("gcd", out_gcd, g);
    check("zero", out_zero, z);
`ifdef GCD_STEPS_EN
    check("steps", out_steps, s);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_gcd", out_gcd, g);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int unsigned pa[$], pb[$], exp_g[$];
    int unsigned g, s;
    bit          z;
    int          idx, got, cyc;
    bit          acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_zero", out_zero, 0);
`ifdef GCD_STEPS_EN
    check("rst_out_steps", out_steps, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    run_pair(35, 15, 0);
    run_pair(23, 15, 0);
    run_pair(0, 0, 0);
    run_pair(0, 12, 0);
    run_pair(12, 0, 0);
    run_pair(7, 7, 10);

    // Abort a long computation with reset; previous result (7) must clear.
    in_a     = 8'd255;
    in_b     = 8'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_gcd", out_gcd, 0);
    check("abort_out_zero", out_zero, 0);
`ifdef GCD_STEPS_EN
    check("abort_out_steps", out_steps, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", in_ready, 1);
    check("abort_no_result", out_valid, 0);
    run_pair(255, 1, 0);

    // Back-to-back with in_valid held and out_ready high.
    pa = '{48, 100};
    pb = '{18, 75};
    for (int i = 0; i < 4; i++) begin
      pa.push_back($urandom_range(0, 255));
      pb.push_back($urandom_range(0, 255));
    end
    foreach (pa[i]) begin
      ref_gcd(pa[i], pb[i], g, z, s);
      exp_g.push_back(g);
    end
    out_ready = 1'b1;
    idx       = 0;
    got       = 0;
    cyc       = 0;
    in_valid  = 1'b1;
    in_a      = W'(pa[0]);
    in_b      = W'(pb[0]);
    while (got < pa.size() && cyc < 5000) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        check("b2b_gcd", out_gcd, exp_g[got]);
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < pa.size()) begin
          in_a = W'(pa[idx]);
          in_b = W'(pb[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_count", got, pa.size());
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("b2b_idle", in_ready, 1);

    for (int i = 0; i < 20; i++) begin
      run_pair($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
